// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch-stage program counter with integrated return-address stack
//
// Purpose:
//   Produces the instruction fetch address each cycle. The PC either steps
//   sequentially, is redirected by a branch, is redirected by a call (which
//   also pushes the link address), or is redirected by a return (which pops
//   the link address). The block also supports a stall, a sticky halt with
//   resume, and a configurable reset vector.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   halt, resume   enter / leave the HALTED state
//   stall          freeze PC and RAS for this cycle
//   branch         redirect to PC_branch
//   call           redirect to PC_branch and push PC_out+INSTR_BYTES
//   ret            redirect to top of RAS and pop (PC_branch if RAS is empty)
//   PC_branch      redirect target
//   PC_out         registered fetch address
//   halted         high while in HALTED
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_overflow   one-cycle pulse: call onto a full RAS, oldest entry lost
//   ras_underflow  one-cycle pulse: ret with an empty RAS
module pc_unit_ras #(
    parameter int             PCW         = 32,
    parameter int             INSTR_BYTES = 4,
    parameter logic [PCW-1:0] RESET_VEC   = '0,
    parameter int             RAS_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           halt,
    input  logic           resume,
    input  logic           stall,
    input  logic           branch,
    input  logic           call,
    input  logic           ret,
    input  logic [PCW-1:0] PC_branch,
    output logic [PCW-1:0] PC_out,
    output logic           halted,
    output logic           ras_empty,
    output logic           ras_full,
    output logic           ras_overflow,
    output logic           ras_underflow
);

    localparam int              PTRW    = $clog2(RAS_DEPTH);
    localparam int              CNTW    = $clog2(RAS_DEPTH + 1);
    localparam logic [PCW-1:0]  INC     = PCW'(INSTR_BYTES);
    localparam logic [PTRW-1:0] PTR_MAX = PTRW'(RAS_DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(RAS_DEPTH);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_e;

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push;
    logic [PCW-1:0]  link;
    logic [PTRW-1:0] ptr_inc, ptr_dec;
    logic [PCW-1:0]  ras_q [RAS_DEPTH];

    // ptr_q indexes the next free slot. When the stack is full that slot holds
    // the oldest entry, so a push there is exactly the circular overwrite.
    assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTRW'(1);
    assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PTRW'(1);
    assign link    = pc_q + INC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (halt) begin
                    // PC holds on the halting cycle; every other input is ignored.
                    state_d = S_HALTED;
                end else if (stall) begin
                    // freeze everything
                end else if (ret) begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[ptr_dec];
                        ptr_d = ptr_dec;
                        cnt_d = cnt_q - CNTW'(1);
                    end else begin
                        pc_d  = PC_branch;
                        unf_d = 1'b1;
                    end
                end else if (call) begin
                    pc_d  = PC_branch;
                    push  = 1'b1;
                    ptr_d = ptr_inc;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else if (branch) begin
                    pc_d = PC_branch;
                end else begin
                    pc_d = pc_q + INC;
                end
            end
            S_HALTED: begin
                if (resume && !halt) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VEC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push) begin
                ras_q[ptr_q] <= link;
            end
        end
    end

    assign PC_out        = pc_q;
    assign halted        = (state_q == S_HALTED);
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CNT_MAX);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed self-checking bench for pc_unit_ras
module tb_pc_unit_ras;

    logic        clk;
    logic        rst;
    logic        halt, resume, stall, branch, call, ret;
    logic [31:0] pc_br;

    // u0: default parameters
    logic [31:0] pc0;
    logic        hlt0, emp0, full0, ovf0, unf0;
    // u1: PCW=8
    logic [7:0]  pc1;
    logic        hlt1, emp1, full1, ovf1, unf1;
    // u2: RAS_DEPTH=2
    logic [31:0] pc2;
    logic        hlt2, emp2, full2, ovf2, unf2;

    int n_cmp;
    int n_bad;

    pc_unit_ras u0 (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall),
        .branch(branch), .call(call), .ret(ret), .PC_branch(pc_br),
        .PC_out(pc0), .halted(hlt0), .ras_empty(emp0), .ras_full(full0),
        .ras_overflow(ovf0), .ras_underflow(unf0)
    );

    pc_unit_ras #(.PCW(8)) u1 (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall),
        .branch(branch), .call(call), .ret(ret), .PC_branch(pc_br[7:0]),
        .PC_out(pc1), .halted(hlt1), .ras_empty(emp1), .ras_full(full1),
        .ras_overflow(ovf1), .ras_underflow(unf1)
    );

    pc_unit_ras #(.RAS_DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall),
        .branch(branch), .call(call), .ret(ret), .PC_branch(pc_br),
        .PC_out(pc2), .halted(hlt2), .ras_empty(emp2), .ras_full(full2),
        .ras_overflow(ovf2), .ras_underflow(unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        halt = 0; resume = 0; stall = 0; branch = 0; call = 0; ret = 0; pc_br = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc0 !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want %h", pc0, 32'h0); end
        n_cmp++; if ({hlt0, emp0, full0, ovf0, unf0} !== 5'b01000) begin n_bad++; $display("FAIL rst_flags got %b want %b", {hlt0, emp0, full0, ovf0, unf0}, 5'b01000); end
        n_cmp++; if ({hlt1, emp1, full1, ovf1, unf1} !== 5'b01000) begin n_bad++; $display("FAIL rst_flags_u1 got %b want %b", {hlt1, emp1, full1, ovf1, unf1}, 5'b01000); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (pc0 !== 32'(4 * i)) begin n_bad++; $display("FAIL rst_seq%0d got %h want %h", i, pc0, 32'(4 * i)); end
        end
        n_cmp++; if (hlt0 !== 1'b0 || emp0 !== 1'b1) begin n_bad++; $display("FAIL rst_idle_flags got %b%b want 01", hlt0, emp0); end
    endtask

    task automatic test_call_ret();
        do_reset();
        branch = 1; pc_br = 32'h100; step(); branch = 0;
        n_cmp++; if (pc0 !== 32'h100) begin n_bad++; $display("FAIL br_pc got %h want %h", pc0, 32'h100); end
        call = 1; pc_br = 32'h400; step(); call = 0;
        n_cmp++; if (pc0 !== 32'h400) begin n_bad++; $display("FAIL call_pc got %h want %h", pc0, 32'h400); end
        n_cmp++; if (emp0 !== 1'b0) begin n_bad++; $display("FAIL call_empty got %b want 0", emp0); end
        step();
        n_cmp++; if (pc0 !== 32'h404) begin n_bad++; $display("FAIL call_seq got %h want %h", pc0, 32'h404); end
        ret = 1; branch = 1; pc_br = 32'h999; step(); ret = 0; branch = 0;
        n_cmp++; if (pc0 !== 32'h104) begin n_bad++; $display("FAIL ret_pc got %h want %h", pc0, 32'h104); end
        n_cmp++; if (emp0 !== 1'b1 || unf0 !== 1'b0) begin n_bad++; $display("FAIL ret_flags got %b%b want 10", emp0, unf0); end
    endtask

    task automatic test_overflow();
        do_reset();
        branch = 1; pc_br = 32'h10; step(); branch = 0;
        call = 1; pc_br = 32'h20; step();
        pc_br = 32'h30; step();
        n_cmp++; if (full2 !== 1'b1 || ovf2 !== 1'b0) begin n_bad++; $display("FAIL ovf_full got %b%b want 10", full2, ovf2); end
        pc_br = 32'h40; step(); call = 0;
        n_cmp++; if (pc2 !== 32'h40) begin n_bad++; $display("FAIL ovf_pc got %h want %h", pc2, 32'h40); end
        n_cmp++; if (ovf2 !== 1'b1 || full2 !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got %b%b want 11", ovf2, full2); end
        ret = 1; step();
        n_cmp++; if (pc2 !== 32'h34 || ovf2 !== 1'b0) begin n_bad++; $display("FAIL ovf_ret1 got %h/%b want 34/0", pc2, ovf2); end
        step();
        n_cmp++; if (pc2 !== 32'h24 || emp2 !== 1'b1) begin n_bad++; $display("FAIL ovf_ret2 got %h/%b want 24/1", pc2, emp2); end
        pc_br = 32'h80; step(); ret = 0;
        n_cmp++; if (pc2 !== 32'h80 || unf2 !== 1'b1) begin n_bad++; $display("FAIL unf_pc got %h/%b want 80/1", pc2, unf2); end
        n_cmp++; if (emp2 !== 1'b1) begin n_bad++; $display("FAIL unf_empty got %b want 1", emp2); end
        step();
        n_cmp++; if (pc2 !== 32'h84 || unf2 !== 1'b0) begin n_bad++; $display("FAIL unf_clear got %h/%b want 84/0", pc2, unf2); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1; call = 1; pc_br = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc0 !== 32'h0 || emp0 !== 1'b1) begin n_bad++; $display("FAIL stall%0d got %h/%b want 0/1", i, pc0, emp0); end
        end
        stall = 0; step(); call = 0;
        n_cmp++; if (pc0 !== 32'h300 || emp0 !== 1'b0) begin n_bad++; $display("FAIL stall_call got %h/%b want 300/0", pc0, emp0); end
        ret = 1; step(); ret = 0;
        n_cmp++; if (pc0 !== 32'h4 || emp0 !== 1'b1) begin n_bad++; $display("FAIL stall_ret got %h/%b want 4/1", pc0, emp0); end
    endtask

    task automatic test_halt();
        do_reset();
        branch = 1; pc_br = 32'h200; step();
        halt = 1; pc_br = 32'h500; step(); halt = 0;
        n_cmp++; if (pc0 !== 32'h200 || hlt0 !== 1'b1) begin n_bad++; $display("FAIL halt_enter got %h/%b want 200/1", pc0, hlt0); end
        call = 1; step(); call = 0;
        n_cmp++; if (pc0 !== 32'h200 || hlt0 !== 1'b1 || emp0 !== 1'b1) begin n_bad++; $display("FAIL halt_frozen got %h/%b/%b want 200/1/1", pc0, hlt0, emp0); end
        branch = 0; resume = 1; halt = 1; step(); halt = 0;
        n_cmp++; if (hlt0 !== 1'b1) begin n_bad++; $display("FAIL halt_beats_resume got %b want 1", hlt0); end
        step(); resume = 0;
        n_cmp++; if (pc0 !== 32'h200 || hlt0 !== 1'b0) begin n_bad++; $display("FAIL resume got %h/%b want 200/0", pc0, hlt0); end
        step();
        n_cmp++; if (pc0 !== 32'h204) begin n_bad++; $display("FAIL resume_next got %h want %h", pc0, 32'h204); end
    endtask

    task automatic test_wrap_and_midreset();
        do_reset();
        branch = 1; pc_br = 32'hFC; step(); branch = 0;
        n_cmp++; if (pc1 !== 8'hFC) begin n_bad++; $display("FAIL wrap_setup got %h want fc", pc1); end
        step();
        n_cmp++; if (pc1 !== 8'h00) begin n_bad++; $display("FAIL wrap got %h want 00", pc1); end
        call = 1; pc_br = 32'h50; step();
        n_cmp++; if (emp0 !== 1'b0 || emp1 !== 1'b0) begin n_bad++; $display("FAIL midrst_setup got %b%b want 00", emp0, emp1); end
        rst = 1; step(); rst = 0; call = 0;
        n_cmp++; if (pc0 !== 32'h0 || emp0 !== 1'b1) begin n_bad++; $display("FAIL midrst_u0 got %h/%b want 0/1", pc0, emp0); end
        n_cmp++; if (pc1 !== 8'h0 || emp1 !== 1'b1) begin n_bad++; $display("FAIL midrst_u1 got %h/%b want 0/1", pc1, emp1); end
        ret = 1; pc_br = 32'h60; step(); ret = 0;
        n_cmp++; if (pc0 !== 32'h60 || unf0 !== 1'b1) begin n_bad++; $display("FAIL midrst_ret got %h/%b want 60/1", pc0, unf0); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_call_ret();
        test_overflow();
        test_stall();
        test_halt();
        test_wrap_and_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
